// File: rtl/shift_pkg.sv
// Shared shift-request definitions used by the ALU, the LSU and shift_arbiter.
//   SHIFT_LEFT / SHIFT_RIGHT : encodings of the func3 direction bit
//   REQ_ALU / REQ_LSU        : requester ids reported on rsp_id
//   shift_req_t              : one shift request (operand, amount, direction, arithmetic flag)
package shift_pkg;

  localparam logic SHIFT_LEFT  = 1'b1;
  localparam logic SHIFT_RIGHT = 1'b0;
  localparam logic REQ_ALU     = 1'b0;
  localparam logic REQ_LSU     = 1'b1;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  shamt;
    logic        func3;
    logic        is_sra;
  } shift_req_t;

  // Arithmetic fill only applies to right shifts.
  function automatic logic eff_arith(input shift_req_t r);
    return r.is_sra & (r.func3 == SHIFT_RIGHT);
  endfunction

endpackage

// File: rtl/barrelshifter32.sv
// 32-bit barrel shifter, purely combinational.
//   data_i   : operand
//   s_i      : shift amount 0..31
//   left_i   : 1 = shift left (zero fill), 0 = shift right
//   arith_i  : right shifts fill with data_i[31] when set (ignored for left shifts)
//   result_o : shifted operand
module barrelshifter32 (
  input  logic [31:0] data_i,
  input  logic [4:0]  s_i,
  input  logic        left_i,
  input  logic        arith_i,
  output logic [31:0] result_o
);

  logic        fill;
  logic [63:0] ext;

  always_comb begin
    fill     = arith_i & ~left_i & data_i[31];
    // Right shift of a sign/zero-extended 64-bit word; low half is the result.
    ext      = {{32{fill}}, data_i} >> s_i;
    result_o = left_i ? (data_i << s_i) : ext[31:0];
  end

endmodule

// File: rtl/shift_arbiter_rr_arb2.sv
// Two-way arbiter producing a one-hot grant.
//   clk_i, rst_i : clock and asynchronous active-high reset
//   req_i        : request vector, bit n = port n valid
//   advance_i    : a granted request actually transferred this cycle
//   grant_o      : one-hot grant (all zero when nothing requests)
// FAIR = 1 gives round-robin on ties; FAIR = 0 is fixed priority for port 0.
module rr_arb2 #(
  parameter int unsigned FAIR = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  // 1 = port 1 was granted last, so port 0 wins the next tie.
  logic last_q;

  always_comb begin
    grant_o = 2'b00;
    if (FAIR == 0) begin
      if (req_i[0])      grant_o = 2'b01;
      else if (req_i[1]) grant_o = 2'b10;
    end else begin
      unique case (req_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
        default: grant_o = 2'b00;
      endcase
    end
  end

  // A stalled grant does not move the pointer; only a real transfer does.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (advance_i) begin
      last_q <= grant_o[1];
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one barrelshifter32 between the ALU (port 0) and LSU alignment (port 1).
//   clk, rst                 : clock, asynchronous active-high reset
//   reqN_valid/ready         : request handshake for port N
//   reqN_data/shamt/func3/is_sra : request payload for port N
//   rsp_valid/ready          : one-entry result register handshake
//   rsp_data, rsp_id         : shifted result and the port that produced it
//   op_count                 : completed responses, wraps
// The shifter is driven combinationally from the granted request and its result is
// captured in the output register, giving one cycle of latency and 1 op/cycle throughput.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int unsigned FAIR  = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_data,
  input  logic [4:0]       req0_shamt,
  input  logic             req0_func3,
  input  logic             req0_is_sra,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_data,
  input  logic [4:0]       req1_shamt,
  input  logic             req1_func3,
  input  logic             req1_is_sra,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_id,
  output logic [CNT_W-1:0] op_count
);

  localparam logic StEmpty = 1'b0;
  localparam logic StFull  = 1'b1;

  logic             state_q, state_d;
  logic [31:0]      data_q;
  logic             id_q;
  logic [CNT_W-1:0] count_q;

  shift_req_t  req0, req1, sel;
  logic [1:0]  grant;
  logic        can_accept;
  logic        accept;
  logic [31:0] shift_result;

  assign req0 = '{data: req0_data, shamt: req0_shamt, func3: req0_func3, is_sra: req0_is_sra};
  assign req1 = '{data: req1_data, shamt: req1_shamt, func3: req1_func3, is_sra: req1_is_sra};

  rr_arb2 #(
    .FAIR(FAIR)
  ) u_arb (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    ({req1_valid, req0_valid}),
    .advance_i(accept),
    .grant_o  (grant)
  );

  always_comb begin
    can_accept = (state_q == StEmpty) | rsp_ready;
    // Ready is masked during reset so nothing is accepted while it is asserted.
    req0_ready = grant[0] & can_accept & ~rst;
    req1_ready = grant[1] & can_accept & ~rst;
    accept     = req0_ready | req1_ready;
    sel        = grant[1] ? req1 : req0;
  end

  barrelshifter32 u_shifter (
    .data_i  (sel.data),
    .s_i     (sel.shamt),
    .left_i  (sel.func3 == SHIFT_LEFT),
    .arith_i (eff_arith(sel)),
    .result_o(shift_result)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (accept) state_d = StFull;
      StFull:  if (rsp_ready && !accept) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      data_q  <= '0;
      id_q    <= REQ_ALU;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q <= shift_result;
        id_q   <= grant[1] ? REQ_LSU : REQ_ALU;
      end
      if ((state_q == StFull) && rsp_ready) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign rsp_valid = (state_q == StFull);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;
  assign op_count  = count_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: dut0 is round-robin (FAIR=1), dut1 fixed priority (FAIR=0);
// both see identical stimulus and are checked against a cycle-level reference model.
module tb_shift_arbiter;
  import shift_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid [2];
  shift_req_t  req [2];
  logic        rsp_ready;

  logic        rdy [2][2];
  logic        rv [2];
  logic [31:0] rd [2];
  logic        ri [2];
  logic [15:0] oc [2];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  shift_arbiter #(.FAIR(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst),
    .req0_valid(req_valid[0]), .req0_ready(rdy[0][0]), .req0_data(req[0].data),
    .req0_shamt(req[0].shamt), .req0_func3(req[0].func3), .req0_is_sra(req[0].is_sra),
    .req1_valid(req_valid[1]), .req1_ready(rdy[0][1]), .req1_data(req[1].data),
    .req1_shamt(req[1].shamt), .req1_func3(req[1].func3), .req1_is_sra(req[1].is_sra),
    .rsp_valid(rv[0]), .rsp_ready(rsp_ready), .rsp_data(rd[0]), .rsp_id(ri[0]),
    .op_count(oc[0])
  );

  shift_arbiter #(.FAIR(0), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst),
    .req0_valid(req_valid[0]), .req0_ready(rdy[1][0]), .req0_data(req[0].data),
    .req0_shamt(req[0].shamt), .req0_func3(req[0].func3), .req0_is_sra(req[0].is_sra),
    .req1_valid(req_valid[1]), .req1_ready(rdy[1][1]), .req1_data(req[1].data),
    .req1_shamt(req[1].shamt), .req1_func3(req[1].func3), .req1_is_sra(req[1].is_sra),
    .rsp_valid(rv[1]), .rsp_ready(rsp_ready), .rsp_data(rd[1]), .rsp_id(ri[1]),
    .op_count(oc[1])
  );

  // Reference model state, one set per DUT.
  logic        m_full [2];
  logic [31:0] m_data [2];
  logic        m_id [2];
  logic        m_last [2];   // port granted on the most recent transfer
  logic [15:0] m_cnt [2];
  logic        nx_full [2];
  logic [31:0] nx_data [2];
  logic        nx_id [2];
  logic        nx_last [2];
  logic [15:0] nx_cnt [2];
  logic        xf [2];       // dut0 transfers this cycle, drives stimulus hold

  function automatic logic [31:0] ref_shift(input shift_req_t r);
    logic [31:0] res;
    if (r.func3) return r.data << r.shamt;
    res = r.data >> r.shamt;
    if (r.is_sra && r.data[31]) res = res | ~(32'hFFFF_FFFF >> r.shamt);
    return res;
  endfunction

  function automatic logic [1:0] m_grant(input int k);
    if (req_valid[0] && req_valid[1]) begin
      if (k == 1) return 2'b01;
      return (m_last[k] == 1'b1) ? 2'b01 : 2'b10;
    end
    if (req_valid[0]) return 2'b01;
    if (req_valid[1]) return 2'b10;
    return 2'b00;
  endfunction

  function automatic shift_req_t rand_req();
    shift_req_t r;
    case ($urandom_range(0, 3))
      0:       r.data = 32'h8000_0000 | $urandom;
      1:       r.data = 32'h7FFF_FFFF & $urandom;
      default: r.data = $urandom;
    endcase
    r.shamt  = 5'($urandom_range(0, 31));
    r.func3  = 1'($urandom_range(0, 1));
    r.is_sra = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d got=%h exp=%h @%0t", name, k, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_full[k] = 1'b0; m_data[k] = '0; m_id[k] = 1'b0; m_last[k] = 1'b1; m_cnt[k] = '0;
    end
    xf[0] = 1'b0; xf[1] = 1'b0;
  endtask

  // Asserts reset mid-cycle and checks its asynchronous effect immediately.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      chk("rst_valid", k, 32'(rv[k]), 32'(0));
      chk("rst_count", k, 32'(oc[k]), 32'(0));
      chk("rst_data", k, rd[k], 32'(0));
      chk("rst_id", k, 32'(ri[k]), 32'(0));
      chk("rst_ready0", k, 32'(rdy[k][0]), 32'(0));
      chk("rst_ready1", k, 32'(rdy[k][1]), 32'(0));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One clock: check outputs at the negedge against the model, then advance the model.
  task automatic tick();
    logic [1:0] g;
    logic       can;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      g   = m_grant(k);
      can = !m_full[k] || rsp_ready;
      chk("req0_ready", k, 32'(rdy[k][0]), 32'(g[0] & can));
      chk("req1_ready", k, 32'(rdy[k][1]), 32'(g[1] & can));
      chk("rsp_valid", k, 32'(rv[k]), 32'(m_full[k]));
      if (m_full[k]) begin
        chk("rsp_data", k, rd[k], m_data[k]);
        chk("rsp_id", k, 32'(ri[k]), 32'(m_id[k]));
      end
      chk("op_count", k, 32'(oc[k]), 32'(m_cnt[k]));
      nx_cnt[k]  = (m_full[k] && rsp_ready) ? m_cnt[k] + 16'd1 : m_cnt[k];
      nx_full[k] = m_full[k] && !rsp_ready;
      nx_data[k] = m_data[k];
      nx_id[k]   = m_id[k];
      nx_last[k] = m_last[k];
      if (can && g != 2'b00) begin
        nx_full[k] = 1'b1;
        nx_id[k]   = g[1];
        nx_data[k] = ref_shift(req[g[1] ? 1 : 0]);
        nx_last[k] = g[1];
      end
      if (k == 0) begin
        xf[0] = g[0] & can;
        xf[1] = g[1] & can;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_full[k] = nx_full[k]; m_data[k] = nx_data[k]; m_id[k] = nx_id[k];
      m_last[k] = nx_last[k]; m_cnt[k] = nx_cnt[k];
    end
  endtask

  typedef struct {
    int          port;
    shift_req_t  r;
    logic [31:0] exp;
  } vec_t;

  vec_t       vecs [10];
  shift_req_t p;
  logic [31:0] held;
  int         streak;

  initial begin
    vecs[0] = '{0, '{32'h8000_0001, 5'd1,  1'b0, 1'b1}, 32'hC000_0000};
    vecs[1] = '{1, '{32'h0000_00FF, 5'd8,  1'b1, 1'b1}, 32'h0000_FF00};
    vecs[2] = '{1, '{32'h0000_00FF, 5'd0,  1'b1, 1'b0}, 32'h0000_00FF};
    vecs[3] = '{0, '{32'h8000_0000, 5'd31, 1'b0, 1'b1}, 32'hFFFF_FFFF};
    vecs[4] = '{0, '{32'h8000_0000, 5'd31, 1'b0, 1'b0}, 32'h0000_0001};
    vecs[5] = '{1, '{32'h0000_0001, 5'd31, 1'b1, 1'b0}, 32'h8000_0000};
    vecs[6] = '{0, '{32'hF0F0_1234, 5'd4,  1'b0, 1'b0}, 32'h0F0F_0123};
    vecs[7] = '{1, '{32'h7000_0000, 5'd4,  1'b0, 1'b1}, 32'h0700_0000};
    vecs[8] = '{0, '{32'h8000_0000, 5'd0,  1'b0, 1'b1}, 32'h8000_0000};
    vecs[9] = '{1, '{32'hFFFF_FFFF, 5'd16, 1'b1, 1'b0}, 32'hFFFF_0000};

    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    req[0] = '0; req[1] = '0;
    rsp_ready = 1'b1;
    #2;
    do_reset();

    // Single ops from the table, one result per vector the following cycle.
    foreach (vecs[i]) begin
      req_valid[vecs[i].port] = 1'b1;
      req[vecs[i].port]       = vecs[i].r;
      tick();
      req_valid[0] = 1'b0; req_valid[1] = 1'b0;
      for (int k = 0; k < 2; k++) begin
        chk("vec_data", k, rd[k], vecs[i].exp);
        chk("vec_id", k, 32'(ri[k]), 32'(vecs[i].port));
      end
    end
    tick();

    // Both ports contend for four cycles.
    do_reset();
    req_valid[0] = 1'b1; req_valid[1] = 1'b1;
    req[0] = rand_req(); req[1] = rand_req();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_id", 0, 32'(ri[0]), 32'(i % 2));
      chk("fixed_id", 1, 32'(ri[1]), 32'(0));
      if (xf[0]) req[0] = rand_req();
      if (xf[1]) req[1] = rand_req();
    end
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    tick();

    // Stalled output register blocks port 1, then releases it.
    req_valid[0] = 1'b1; req[0] = rand_req(); rsp_ready = 1'b1;
    held = ref_shift(req[0]);
    tick();
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b1; p = rand_req(); req[1] = p; rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        chk("stall_ready1", k, 32'(rdy[k][1]), 32'(0));
        chk("stall_held", k, rd[k], held);
      end
    end
    rsp_ready = 1'b1;
    tick();
    req_valid[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("release_id", k, 32'(ri[k]), 32'(1));
      chk("release_data", k, rd[k], ref_shift(p));
    end
    tick();

    // Eight back-to-back ops from a clean reset.
    do_reset();
    streak = 0;
    req_valid[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req[0] = rand_req();
      tick();
      if (rv[0]) streak++;
    end
    req_valid[0] = 1'b0;
    tick();
    chk("b2b_streak", 0, 32'(streak), 32'(8));
    for (int k = 0; k < 2; k++) chk("b2b_count", k, 32'(oc[k]), 32'(8));

    // Reset while full with both ports requesting.
    req_valid[0] = 1'b1; req_valid[1] = 1'b1;
    req[0] = rand_req(); req[1] = rand_req(); rsp_ready = 1'b0;
    tick();
    do_reset();
    rsp_ready = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) chk("post_rst_id", k, 32'(ri[k]), 32'(0));
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    tick();

    // Randomised traffic honouring valid/payload hold until ready.
    for (int c = 0; c < 600; c++) begin
      for (int pi = 0; pi < 2; pi++) begin
        if (!req_valid[pi] || xf[pi]) begin
          req_valid[pi] = ($urandom_range(0, 2) != 0);
          req[pi]       = rand_req();
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
